// File: rtl/ahb_mux_pkg.sv
// Shared types and constants for the AHB-Lite slave response multiplexer.
// Holds the data-phase state encoding, HTRANS/HRESP encodings and the
// helper that sizes the registered port index.
package ahb_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLAVE = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } mux_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // A single-port mux still needs a one-bit index register.
  function automatic int idxWidth(input int nports);
    return (nports <= 1) ? 1 : $clog2(nports);
  endfunction

endpackage

// File: rtl/ahb_mux_onehot_enc.sv
// Priority encoder from the masked HSEL vector to a port index.
// The lowest set bit wins so a faulty multi-hot decoder still yields a
// deterministic selection; valid_o is low when no bit is set.
module ahb_mux_onehot_enc
  import ahb_mux_pkg::*;
#(
  parameter int NPORTS = 10,
  parameter int IW     = idxWidth(NPORTS)
) (
  input  logic [NPORTS-1:0] sel_i,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (sel_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_mux_np.sv
// Parametrised AHB-Lite slave-side response multiplexer with a built-in
// default slave that answers unmapped or disabled accesses with a two-cycle
// ERROR. Defining AHB_SLAVE_MUX_TIMEOUT_EN adds a stall watchdog that
// aborts a hung slave into the ERROR sequence and reports the port.
module ahb_slave_mux_np
  import ahb_mux_pkg::*;
#(
  parameter int                NPORTS         = 10,
  parameter int                DW             = 32,
  parameter logic [NPORTS-1:0] PORT_EN        = {NPORTS{1'b1}},
  parameter int                TIMEOUT_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HREADY,
  input  logic [1:0]           HTRANS,
  input  logic [NPORTS-1:0]    HSEL,
  input  logic [NPORTS-1:0]    HREADYOUT_S,
  input  logic [NPORTS-1:0]    HRESP_S,
  input  logic [NPORTS*DW-1:0] HRDATA_S,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [DW-1:0]        HRDATA,
  output logic                 TIMEOUT_PULSE,
  output logic [4:0]           TIMEOUT_PORT
);

  localparam int IW = idxWidth(NPORTS);

  mux_state_e        state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic [NPORTS-1:0] selMasked;
  logic [IW-1:0]     encIdx;
  logic              encValid;
  logic              transActive;
  logic              slvReady;
  logic              slvResp;
  logic [DW-1:0]     slvData;
  logic              abort;

  // Disabled ports are removed before encoding so they can never be selected.
  assign selMasked   = HSEL & PORT_EN;
  assign transActive = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  ahb_mux_onehot_enc #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_enc (
    .sel_i   (selMasked),
    .idx_o   (encIdx),
    .valid_o (encValid)
  );

  assign slvReady = HREADYOUT_S[sel_q];
  assign slvResp  = HRESP_S[sel_q];
  assign slvData  = HRDATA_S[int'(sel_q)*DW +: DW];

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;
  logic [4:0]    port_q;

  // A slave that becomes ready on the limit cycle is not stalled, so it wins.
  assign abort = (state_q == ST_SLAVE) && !slvReady &&
                 (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count only cycles spent waiting on the selected slave in this data phase.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_SLAVE) && !slvReady && !HREADY && !abort) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Watchdog counter, abort strobe and the port that last timed out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      port_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= abort;
      if (abort) begin
        port_q <= 5'(sel_q);
      end
    end
  end

  assign TIMEOUT_PULSE = pulse_q;
  assign TIMEOUT_PORT  = port_q;
`else
  assign abort         = 1'b0;
  assign TIMEOUT_PULSE = 1'b0;
  assign TIMEOUT_PORT  = 5'd0;
`endif

  // Data-phase ownership and selected port registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state: ERR1 always completes, a watchdog abort overrides the stall,
  // otherwise a new address phase is taken whenever HREADY is high.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (abort) begin
      state_d = ST_ERR1;
    end else if (HREADY) begin
      if (encValid) begin
        state_d = ST_SLAVE;
        sel_d   = encIdx;
      end else if (transActive) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Response mux: the owning slave in SLAVE, the default slave otherwise.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_SLAVE: begin
        HREADYOUT = slvReady;
        HRESP     = slvResp;
        HRDATA    = slvData;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        HRESP     = HRESP_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // More than one enabled select in an address phase means the decoder is broken.
  assert property (@(posedge HCLK) disable iff (!HRESETn) HREADY |-> $onehot0(selMasked));

endmodule

// File: tb/tb_ahb_slave_mux_np.sv
// Self-checking bench for ahb_slave_mux_np (4 ports, port 1 disabled).
// Builds with or without AHB_SLAVE_MUX_TIMEOUT_EN; the expected watchdog
// behaviour follows the macro.
module tb_ahb_slave_mux_np;

  localparam int         NP = 4;
  localparam logic [3:0] EN = 4'b1101;
  localparam int         TO = 8;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic          HCLK;
  logic          HRESETn;
  logic          HREADY;
  logic [1:0]    HTRANS;
  logic [NP-1:0] HSEL;
  logic [NP-1:0] HREADYOUT_S;
  logic [NP-1:0] HRESP_S;
  logic [NP*32-1:0] HRDATA_S;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic          TIMEOUT_PULSE;
  logic [4:0]    TIMEOUT_PORT;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] lastPort = 5'd0;

  ahb_slave_mux_np #(
    .NPORTS         (NP),
    .DW             (32),
    .PORT_EN        (EN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HREADY        (HREADY),
    .HTRANS        (HTRANS),
    .HSEL          (HSEL),
    .HREADYOUT_S   (HREADYOUT_S),
    .HRESP_S       (HRESP_S),
    .HRDATA_S      (HRDATA_S),
    .HREADYOUT     (HREADYOUT),
    .HRESP         (HRESP),
    .HRDATA        (HRDATA),
    .TIMEOUT_PULSE (TIMEOUT_PULSE),
    .TIMEOUT_PORT  (TIMEOUT_PORT)
  );

  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // Random responses on every port; port 1 always offers a recognisable word.
  task automatic applyStimulus(input logic [3:0] hsel, input logic [1:0] htrans);
    for (int i = 0; i < NP; i++) begin
      HREADYOUT_S[i]         = 1'($urandom);
      HRESP_S[i]             = 1'($urandom);
      HRDATA_S[i*32 +: 32]   = $urandom;
    end
    HRDATA_S[63:32] = 32'h12345678;
    HSEL   = hsel;
    HTRANS = htrans;
  endtask

  task automatic checkOutput(input string tag, input logic expRdy, input logic expResp,
                             input logic [31:0] expData, input logic expPulse,
                             input logic [4:0] expPort);
    #1;
    checks++;
    assert ({HREADYOUT, HRESP, HRDATA, TIMEOUT_PULSE, TIMEOUT_PORT} ===
            {expRdy, expResp, expData, expPulse, expPort})
    else begin
      errors++;
      $error("[TB] FAIL %s: got rdy=%b resp=%b data=%h pulse=%b port=%0d, expected rdy=%b resp=%b data=%h pulse=%b port=%0d",
             tag, HREADYOUT, HRESP, HRDATA, TIMEOUT_PULSE, TIMEOUT_PORT,
             expRdy, expResp, expData, expPulse, expPort);
    end
  endtask

  // One transfer from an idle bus: address phase, then the data phase the
  // reference rules predict, ending back on an idle bus.
  task automatic runTransfer(input string tag, input int p, input logic [1:0] htrans,
                             input int stalls, input logic slvResp, input logic [31:0] data);
    logic [3:0]  hsel;
    logic        mapped;
    logic [31:0] junk;
    hsel   = (p >= 0) ? 4'(1 << p) : 4'b0000;
    mapped = (p >= 0) && EN[p];
    applyStimulus(hsel, htrans);
    checkOutput({tag, "/addr"}, 1'b1, 1'b0, 32'h0, 1'b0, lastPort);
    step;
    if (mapped) begin
      for (int k = 0; k < stalls; k++) begin
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
        if (k == TO) break;
`endif
        applyStimulus(4'b0000, T_IDLE);
        junk = $urandom;
        HREADYOUT_S[p]       = 1'b0;
        HRESP_S[p]           = 1'b0;
        HRDATA_S[p*32 +: 32] = junk;
        checkOutput({tag, "/wait"}, 1'b0, 1'b0, junk, 1'b0, lastPort);
        step;
      end
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
      if (stalls >= TO) begin
        applyStimulus(4'b0000, T_IDLE);
        HREADYOUT_S[p] = 1'b0;
        lastPort = 5'(p);
        checkOutput({tag, "/abortErr1"}, 1'b0, 1'b1, 32'h0, 1'b1, lastPort);
        step;
        applyStimulus(4'b0000, T_IDLE);
        HREADYOUT_S[p] = 1'b0;
        checkOutput({tag, "/abortErr2"}, 1'b1, 1'b1, 32'h0, 1'b0, lastPort);
        step;
      end else
`endif
      begin
        applyStimulus(4'b0000, T_IDLE);
        HREADYOUT_S[p]       = 1'b1;
        HRESP_S[p]           = slvResp;
        HRDATA_S[p*32 +: 32] = data;
        checkOutput({tag, "/done"}, 1'b1, slvResp, data, 1'b0, lastPort);
        step;
      end
    end else if (htrans[1]) begin
      applyStimulus(4'b0000, T_IDLE);
      checkOutput({tag, "/err1"}, 1'b0, 1'b1, 32'h0, 1'b0, lastPort);
      step;
      applyStimulus(4'b0000, T_IDLE);
      checkOutput({tag, "/err2"}, 1'b1, 1'b1, 32'h0, 1'b0, lastPort);
      step;
    end
  endtask

  initial begin
    logic [31:0] d;
    HRESETn = 1'b0;
    applyStimulus(4'b0000, T_IDLE);
    @(negedge HCLK);
    checkOutput("reset", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    step;
    HRESETn = 1'b1;
    step;

    runTransfer("p2wait3", 2, T_NONSEQ, 3, 1'b0, 32'hDEADBEEF);
    runTransfer("unmapped", -1, T_NONSEQ, 0, 1'b0, 32'h0);
    runTransfer("idleOkay", -1, T_IDLE, 0, 1'b0, 32'h0);
    runTransfer("disabledP1", 1, T_NONSEQ, 0, 1'b0, 32'h0);
    runTransfer("p0err", 0, T_NONSEQ, 1, 1'b1, 32'hA5A5_0001);

    // A new address phase offered during ERR2 must be accepted.
    applyStimulus(4'b0000, T_NONSEQ);
    checkOutput("err2Pipe/addr", 1'b1, 1'b0, 32'h0, 1'b0, lastPort);
    step;
    applyStimulus(4'b0000, T_IDLE);
    checkOutput("err2Pipe/err1", 1'b0, 1'b1, 32'h0, 1'b0, lastPort);
    step;
    applyStimulus(4'b0001, T_NONSEQ);
    checkOutput("err2Pipe/err2", 1'b1, 1'b1, 32'h0, 1'b0, lastPort);
    step;
    applyStimulus(4'b0000, T_IDLE);
    d = 32'hCAFE_F00D;
    HREADYOUT_S[0]   = 1'b1;
    HRESP_S[0]       = 1'b0;
    HRDATA_S[31:0]   = d;
    checkOutput("err2Pipe/p0data", 1'b1, 1'b0, d, 1'b0, lastPort);
    step;

    runTransfer("p3hang", 3, T_NONSEQ, 20, 1'b0, 32'h3333_0000);
    runTransfer("p0after", 0, T_NONSEQ, 0, 1'b0, 32'h0000_0A0A);
    runTransfer("p3ready8th", 3, T_NONSEQ, TO - 1, 1'b0, 32'h8888_7777);

    // Reset while port 2 is stalling returns the outputs immediately.
    applyStimulus(4'b0100, T_NONSEQ);
    checkOutput("rstMid/addr", 1'b1, 1'b0, 32'h0, 1'b0, lastPort);
    step;
    applyStimulus(4'b0000, T_IDLE);
    d = $urandom;
    HREADYOUT_S[2]     = 1'b0;
    HRESP_S[2]         = 1'b0;
    HRDATA_S[95:64]    = d;
    checkOutput("rstMid/stall", 1'b0, 1'b0, d, 1'b0, lastPort);
    HRESETn  = 1'b0;
    lastPort = 5'd0;
    checkOutput("rstMid/async", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    step;
    HRESETn = 1'b1;
    applyStimulus(4'b0000, T_IDLE);
    HREADYOUT_S[2] = 1'b0;
    checkOutput("rstMid/idle", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    step;

    for (int n = 0; n < 40; n++) begin
      runTransfer($sformatf("rnd%0d", n), int'($urandom_range(0, 4)) - 1,
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                  1'($urandom_range(0, 1)), $urandom);
    end

    applyStimulus(4'b0000, T_IDLE);
    checkOutput("finalIdle", 1'b1, 1'b0, 32'h0, 1'b0, lastPort);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
